// File: rtl/poly_stream_rx_pkg.sv
// Shared types for the polynomial stream receiver.
// Fill FSM and frame buffer state encodings.
package poly_stream_rx_pkg;

  typedef enum logic {
    FILL,
    DROP
  } fill_st_e;

  typedef enum logic {
    EMPTY,
    FULL
  } buf_st_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream interface with frame marker.
// The source drives vld/last/data; the sink drives rdy.
interface axis_if #(
  parameter int W = 8
);
  logic         vld;
  logic         rdy;
  logic         last;
  logic [W-1:0] data;

  modport src (
    output vld, last, data,
    input  rdy
  );

  modport sink (
    input  vld, last, data,
    output rdy
  );
endinterface

// File: rtl/poly_frame_buf.sv
// One polynomial frame buffer: indexed coefficient writes,
// an EMPTY/FULL flag, and a clear used on handoff.
module poly_frame_buf
  import poly_stream_rx_pkg::*;
#(
  parameter int N  = 4,
  parameter int QW = 5
) (
  input  logic                  clk,
  input  logic                  s_rst,
  input  logic                  wr_en_i,
  input  logic [idx_w(N)-1:0]   wr_idx_i,
  input  logic [QW-1:0]         wr_data_i,
  input  logic                  set_full_i,
  input  logic                  clr_i,
  output logic [N*QW-1:0]       data_o,
  output logic                  full_o
);

  logic [QW-1:0] mem_q [N];
  buf_st_e       st_q;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      for (int k = 0; k < N; k++) begin
        mem_q[k] <= '0;
      end
      st_q <= EMPTY;
    end else begin
      if (wr_en_i) begin
        mem_q[wr_idx_i] <= wr_data_i;
      end
      if (set_full_i) begin
        st_q <= FULL;
      end else if (clr_i) begin
        st_q <= EMPTY;
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign data_o[k*QW +: QW] = mem_q[k];
  end

  assign full_o = (st_q == FULL);

endmodule

// File: rtl/poly_stream_rx.sv
// Ping-pong assembler: collects N-beat coefficient frames
// into two buffers and presents them oldest-first.
module poly_stream_rx
  import poly_stream_rx_pkg::*;
#(
  parameter int N  = 4,
  parameter int QW = 5
) (
  input  logic            clk,
  input  logic            s_rst,
  axis_if.sink            z,
  output logic [N*QW-1:0] poly_data,
  output logic            poly_vld,
  input  logic            poly_rdy,
  output logic            frame_err
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  fill_st_e      st_q, st_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          wp_q, wp_d;
  logic          rp_q, rp_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;

  logic [1:0]      full;
  logic [1:0]      f_n;
  logic [1:0]      set_full;
  logic [1:0]      clr;
  logic [1:0]      wr_en;
  logic [N*QW-1:0] bdata [2];

  logic beat, wr, is_end, done, free;

  assign beat   = z.vld & rdy_q;
  assign is_end = (cnt_q == LAST_IDX);
  assign wr     = beat & (st_q == FILL);
  assign done   = wr & z.last & is_end;
  assign free   = poly_vld & poly_rdy;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    unique case (st_q)
      FILL: begin
        if (wr) begin
          err_d = z.last ^ is_end;
          cnt_d = (z.last | is_end) ? '0 : cnt_q + 1'b1;
          if (!z.last && is_end) begin
            st_d = DROP;
          end
        end
      end
      DROP: begin
        cnt_d = '0;
        if (beat && z.last) begin
          st_d = FILL;
        end
      end
      default: st_d = FILL;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      set_full[i] = done & (wp_q == 1'(i));
      clr[i]      = free & (rp_q == 1'(i));
      wr_en[i]    = wr & (wp_q == 1'(i));
      f_n[i]      = (full[i] & ~clr[i]) | set_full[i];
    end
  end

  assign wp_d  = wp_q ^ done;
  assign rp_d  = rp_q ^ free;
  // A partial fill always sits in an EMPTY buffer, so stall only on both full.
  assign rdy_d = ~(f_n[0] & f_n[1]) | (st_d == DROP);

  always_ff @(posedge clk) begin
    if (s_rst) begin
      st_q  <= FILL;
      cnt_q <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      rdy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      rdy_q <= rdy_d;
      err_q <= err_d;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_buf
    poly_frame_buf #(
      .N  (N),
      .QW (QW)
    ) u_buf (
      .clk        (clk),
      .s_rst      (s_rst),
      .wr_en_i    (wr_en[i]),
      .wr_idx_i   (cnt_q),
      .wr_data_i  (z.data),
      .set_full_i (set_full[i]),
      .clr_i      (clr[i]),
      .data_o     (bdata[i]),
      .full_o     (full[i])
    );
  end

  assign z.rdy     = rdy_q;
  assign poly_vld  = full[rp_q];
  assign poly_data = bdata[rp_q];
  assign frame_err = err_q;

endmodule

// File: tb/tb_poly_stream_rx.sv
// Bench for poly_stream_rx: frame-level model plus
// directed scenarios with literal expectations.
module tb_poly_stream_rx;

  localparam int N  = 4;
  localparam int QW = 5;

  logic            clk = 1'b0;
  logic            s_rst = 1'b1;
  logic            poly_rdy = 1'b0;
  logic [N*QW-1:0] poly_data;
  logic            poly_vld;
  logic            frame_err;

  axis_if #(QW) zif ();

  poly_stream_rx #(
    .N  (N),
    .QW (QW)
  ) dut (
    .clk       (clk),
    .s_rst     (s_rst),
    .z         (zif),
    .poly_data (poly_data),
    .poly_vld  (poly_vld),
    .poly_rdy  (poly_rdy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*QW-1:0] pk(input int a, input int b,
                                         input int c, input int d);
    logic [N*QW-1:0] r;
    r = '0;
    r[0*QW +: QW] = QW'(a);
    r[1*QW +: QW] = QW'(b);
    r[2*QW +: QW] = QW'(c);
    r[3*QW +: QW] = QW'(d);
    return r;
  endfunction

  // Frame-level model: collected beats, completed-frame FIFO.
  logic [QW-1:0]   cur [$];
  logic [N*QW-1:0] mq  [$];
  bit dropping = 1'b0;
  bit err_next = 1'b0;
  bit rst_seen = 1'b1;
  bit win      = 1'b0;
  int hs_cnt   = 0;
  int err_cnt  = 0;
  int rdy_low  = 0;

  always @(negedge clk) begin
    logic [N*QW-1:0] f;
    bit exp_rdy, acc;
    if (rst_seen) begin
      chk("rst_rdy", 64'(zif.rdy), 64'(0));
      chk("rst_vld", 64'(poly_vld), 64'(0));
      chk("rst_err", 64'(frame_err), 64'(0));
      chk("rst_data", 64'(poly_data), 64'(0));
    end else begin
      chk("m_rdy", 64'(zif.rdy), 64'(mq.size() < 2));
      chk("m_vld", 64'(poly_vld), 64'(mq.size() > 0));
      if (mq.size() > 0) chk("m_data", 64'(poly_data), 64'(mq[0]));
      chk("m_err", 64'(frame_err), 64'(err_next));
      if (win && zif.rdy !== 1'b1) rdy_low++;
    end
    if (frame_err === 1'b1) err_cnt++;
    err_next = 1'b0;
    exp_rdy = !rst_seen && (mq.size() < 2);
    if (s_rst) begin
      mq.delete();
      cur.delete();
      dropping = 1'b0;
      rst_seen = 1'b1;
    end else begin
      acc = zif.vld && exp_rdy;
      if (mq.size() > 0 && poly_rdy) begin
        void'(mq.pop_front());
        hs_cnt++;
      end
      if (acc) begin
        if (dropping) begin
          if (zif.last) dropping = 1'b0;
        end else begin
          cur.push_back(zif.data);
          if (zif.last) begin
            if (cur.size() == N) begin
              f = '0;
              for (int k = 0; k < N; k++) f[k*QW +: QW] = cur[k];
              mq.push_back(f);
            end else begin
              err_next = 1'b1;
            end
            cur.delete();
          end else if (cur.size() == N) begin
            err_next = 1'b1;
            dropping = 1'b1;
            cur.delete();
          end
        end
      end
      rst_seen = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int d, input bit lst);
    bit ok;
    int t;
    zif.vld  = 1'b1;
    zif.data = QW'(d);
    zif.last = lst;
    t = 0;
    do begin
      @(negedge clk);
      ok = (zif.rdy === 1'b1);
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout act=stalled exp=accepted d=%0d", d);
    end
  endtask

  task automatic send_frame(input int a, input int b,
                            input int c, input int d);
    send_beat(a, 1'b0);
    send_beat(b, 1'b0);
    send_beat(c, 1'b0);
    send_beat(d, 1'b1);
  endtask

  task automatic chk_coef(input string nm, input int a, input int b,
                          input int c, input int d);
    chk({nm, "_c0"}, 64'(poly_data[0*QW +: QW]), 64'(a));
    chk({nm, "_c1"}, 64'(poly_data[1*QW +: QW]), 64'(b));
    chk({nm, "_c2"}, 64'(poly_data[2*QW +: QW]), 64'(c));
    chk({nm, "_c3"}, 64'(poly_data[3*QW +: QW]), 64'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, h0;
    time t0;
    zif.vld  = 1'b0;
    zif.last = 1'b0;
    zif.data = '0;
    idle(3);
    s_rst = 1'b0;
    idle(1);
    chk("post_rst_rdy", 64'(zif.rdy), 64'(1));

    // single frame, latency 1
    poly_rdy = 1'b1;
    send_frame(30, 8, 31, 4);
    zif.vld = 1'b0;
    chk("t1_vld", 64'(poly_vld), 64'(1));
    chk_coef("t1", 30, 8, 31, 4);
    chk("t1_err", 64'(frame_err), 64'(0));
    idle(2);
    chk("t1_gone", 64'(poly_vld), 64'(0));

    // two frames held, then drained in order
    poly_rdy = 1'b0;
    send_frame(30, 8, 31, 4);
    send_frame(1, 2, 3, 4);
    zif.vld = 1'b0;
    chk("t2_rdy_lo", 64'(zif.rdy), 64'(0));
    chk_coef("t2a", 30, 8, 31, 4);
    idle(3);
    chk("t2_hold_vld", 64'(poly_vld), 64'(1));
    chk("t2_hold_data", 64'(poly_data), 64'(pk(30, 8, 31, 4)));
    chk("t2_rdy_stay", 64'(zif.rdy), 64'(0));
    poly_rdy = 1'b1;
    idle(1);
    chk("t2_rdy_hi", 64'(zif.rdy), 64'(1));
    chk("t2b_vld", 64'(poly_vld), 64'(1));
    chk_coef("t2b", 1, 2, 3, 4);
    idle(1);
    chk("t2_empty", 64'(poly_vld), 64'(0));

    // short frame
    e0 = err_cnt;
    send_beat(7, 1'b0);
    send_beat(9, 1'b1);
    zif.vld = 1'b0;
    chk("t3_err", 64'(frame_err), 64'(1));
    chk("t3_vld", 64'(poly_vld), 64'(0));
    idle(1);
    chk("t3_err_lo", 64'(frame_err), 64'(0));
    chk("t3_err_cnt", 64'(err_cnt - e0), 64'(1));
    send_frame(1, 2, 3, 4);
    zif.vld = 1'b0;
    chk_coef("t3", 1, 2, 3, 4);
    idle(2);

    // long frame
    e0 = err_cnt;
    for (int k = 0; k < 6; k++) send_beat(10 + k, k == 5);
    zif.vld = 1'b0;
    idle(2);
    chk("t4_err_cnt", 64'(err_cnt - e0), 64'(1));
    chk("t4_vld", 64'(poly_vld), 64'(0));
    send_frame(5, 6, 7, 8);
    zif.vld = 1'b0;
    chk_coef("t4", 5, 6, 7, 8);
    idle(2);

    // reset with one frame full and a partial in flight
    poly_rdy = 1'b0;
    send_frame(30, 8, 31, 4);
    send_beat(1, 1'b0);
    send_beat(2, 1'b0);
    zif.vld = 1'b0;
    chk("t5_pre_vld", 64'(poly_vld), 64'(1));
    s_rst = 1'b1;
    idle(1);
    chk("t5_rst_vld", 64'(poly_vld), 64'(0));
    chk("t5_rst_rdy", 64'(zif.rdy), 64'(0));
    idle(1);
    s_rst = 1'b0;
    idle(1);
    chk("t5_rdy_up", 64'(zif.rdy), 64'(1));
    chk("t5_no_stale", 64'(poly_vld), 64'(0));
    poly_rdy = 1'b1;
    send_frame(30, 8, 31, 4);
    zif.vld = 1'b0;
    chk_coef("t5", 30, 8, 31, 4);
    idle(2);

    // streaming, no bubbles
    h0 = hs_cnt;
    win = 1'b1;
    t0 = $time;
    for (int f = 0; f < 8; f++) send_frame(f, f + 1, f + 2, f + 3);
    chk("t6_elapsed", 64'($time - t0), 64'(8 * N * 10));
    zif.vld = 1'b0;
    idle(3);
    win = 1'b0;
    chk("t6_hs", 64'(hs_cnt - h0), 64'(8));
    chk("t6_rdy_low", 64'(rdy_low), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
